// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write-side front end.
package rf_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 1 << REG_AW;

    localparam logic [REG_AW-1:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    // One-hot register mask; x0 is never marked so it can never become busy.
    function automatic logic [NUM_REGS-1:0] reg_onehot(
        input logic [REG_AW-1:0] rd,
        input logic              en
    );
        reg_onehot = '0;
        if (en && (rd != REG_X0)) begin
            reg_onehot[rd] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO buffering long-latency results until the
// register-file write port is free.
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_head    = r_mem[r_rd_ptr];

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

    // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge CLK) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write arbiter: pipeline writeback has priority, buffered
// long-latency results fill idle slots, and a busy scoreboard drives decode stalls.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              Pipe_Wr,
    input  logic [4:0]        Pipe_Rd,
    input  logic [XLEN-1:0]   Pipe_Data,
    input  logic              Issue_Vld,
    input  logic [4:0]        Issue_Rd,
    input  logic              LL_Vld,
    input  logic [4:0]        LL_Rd,
    input  logic [XLEN-1:0]   LL_Data,
    output logic              LL_Rdy,
    input  logic [4:0]        Rs1_rd,
    input  logic [4:0]        Rs2_rd,
    input  logic [4:0]        Rd_Chk,
    output logic              Hazard_Stall,
    output logic [31:0]       Busy_Vec,
    output logic              Reg_Wr,
    output logic [4:0]        Rd_Wr,
    output logic [XLEN-1:0]   Rd_In
);

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } ll_entry_t;

    ll_entry_t             w_push_entry;
    ll_entry_t             w_head;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_push;
    logic                  w_pipe_sel;
    logic                  w_pop;
    logic [NUM_REGS-1:0]   w_busy_set;
    logic [NUM_REGS-1:0]   w_busy_clr;
    logic [NUM_REGS-1:0]   w_busy_nxt;

    logic [NUM_REGS-1:0]   r_busy;
    logic                  r_reg_wr;
    logic [REG_AW-1:0]     r_rd_wr;
    logic [XLEN-1:0]       r_rd_in;

    assign w_push_entry = '{rd: LL_Rd, data: LL_Data};
    assign LL_Rdy       = ~w_fifo_full;
    assign w_push       = LL_Vld & ~w_fifo_full;

    // A pipeline write to x0 is a no-op and must not steal the slot from the FIFO.
    assign w_pipe_sel   = Pipe_Wr & (Pipe_Rd != REG_X0);
    assign w_pop        = ~w_pipe_sel & ~w_fifo_empty;

    wb_fifo #(
        .WIDTH ($bits(ll_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_ll_fifo (
        .CLK         (CLK),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // Set is applied after clear so a same-cycle reissue keeps the register busy.
    always_comb begin
        w_busy_set = reg_onehot(Issue_Rd, Issue_Vld);
        w_busy_clr = reg_onehot(w_head.rd, w_pop);
        w_busy_nxt = (r_busy & ~w_busy_clr) | w_busy_set;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_reg_wr <= 1'b0;
            r_rd_wr  <= '0;
            r_rd_in  <= '0;
        end else if (w_pipe_sel) begin
            r_reg_wr <= 1'b1;
            r_rd_wr  <= Pipe_Rd;
            r_rd_in  <= Pipe_Data;
        end else if (w_pop) begin
            r_reg_wr <= 1'b1;
            r_rd_wr  <= w_head.rd;
            r_rd_in  <= w_head.data;
        end else begin
            r_reg_wr <= 1'b0;
        end
    end

    assign Busy_Vec     = r_busy;
    assign Hazard_Stall = r_busy[Rs1_rd] | r_busy[Rs2_rd] | r_busy[Rd_Chk];
    assign Reg_Wr       = r_reg_wr;
    assign Rd_Wr        = r_rd_wr;
    assign Rd_In        = r_rd_in;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: directed scenarios followed by random
// traffic, with a queue-based reference model of the FIFO and scoreboard.
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    localparam int DEPTH = 2;

    logic        CLK;
    logic        rst_n;
    logic        Pipe_Wr;
    logic [4:0]  Pipe_Rd;
    logic [31:0] Pipe_Data;
    logic        Issue_Vld;
    logic [4:0]  Issue_Rd;
    logic        LL_Vld;
    logic [4:0]  LL_Rd;
    logic [31:0] LL_Data;
    logic        LL_Rdy;
    logic [4:0]  Rs1_rd;
    logic [4:0]  Rs2_rd;
    logic [4:0]  Rd_Chk;
    logic        Hazard_Stall;
    logic [31:0] Busy_Vec;
    logic        Reg_Wr;
    logic [4:0]  Rd_Wr;
    logic [31:0] Rd_In;

    rf_wb_arbiter #(.XLEN(32), .FIFO_DEPTH(DEPTH)) dut (
        .CLK          (CLK),
        .rst_n        (rst_n),
        .Pipe_Wr      (Pipe_Wr),
        .Pipe_Rd      (Pipe_Rd),
        .Pipe_Data    (Pipe_Data),
        .Issue_Vld    (Issue_Vld),
        .Issue_Rd     (Issue_Rd),
        .LL_Vld       (LL_Vld),
        .LL_Rd        (LL_Rd),
        .LL_Data      (LL_Data),
        .LL_Rdy       (LL_Rdy),
        .Rs1_rd       (Rs1_rd),
        .Rs2_rd       (Rs2_rd),
        .Rd_Chk       (Rd_Chk),
        .Hazard_Stall (Hazard_Stall),
        .Busy_Vec     (Busy_Vec),
        .Reg_Wr       (Reg_Wr),
        .Rd_Wr        (Rd_Wr),
        .Rd_In        (Rd_In)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    typedef struct {
        wb_entry_t e;
        int        due;
    } exp_t;

    exp_t        exp_q[$];
    wb_entry_t   model_fifo[$];
    logic [31:0] model_busy;
    logic [4:0]  ll_pend[$];
    logic [4:0]  last_rd;
    logic [31:0] last_data;
    bit          last_acc;
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One clock of stimulus; the model advances by the arbitration rules.
    task automatic step(input bit pw, input logic [4:0] prd, input logic [31:0] pdata,
                        input bit iv, input logic [4:0] ird,
                        input bit lv, input logic [4:0] lrd, input logic [31:0] ldata,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rdc);
        bit        rdy;
        wb_entry_t h;
        exp_t      x;
        @(negedge CLK);
        Pipe_Wr = pw;  Pipe_Rd = prd;  Pipe_Data = pdata;
        Issue_Vld = iv; Issue_Rd = ird;
        LL_Vld = lv;   LL_Rd = lrd;    LL_Data = ldata;
        Rs1_rd = rs1;  Rs2_rd = rs2;   Rd_Chk = rdc;
        #1;
        rdy = (model_fifo.size() < DEPTH);
        check("ll_rdy", 64'(LL_Rdy), 64'(rdy));
        check("busy_vec", 64'(Busy_Vec), 64'(model_busy));
        check("hazard", 64'(Hazard_Stall), 64'(model_busy[rs1] | model_busy[rs2] | model_busy[rdc]));
        last_acc = lv && rdy;
        if (pw && prd != 5'd0) begin
            x.e.rd = prd; x.e.data = pdata; x.due = cyc + 1;
            exp_q.push_back(x);
        end else if (model_fifo.size() > 0) begin
            h = model_fifo.pop_front();
            x.e = h; x.due = cyc + 1;
            exp_q.push_back(x);
            if (h.rd != 5'd0) model_busy[h.rd] = 1'b0;
        end
        if (last_acc) begin
            h.rd = lrd; h.data = ldata;
            model_fifo.push_back(h);
        end
        if (iv && ird != 5'd0) model_busy[ird] = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic issue(input logic [4:0] rd);
        step(0, 0, 0, 1, rd, 0, 0, 0, 0, 0, rd);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        rst_n = 1'b0;
        Pipe_Wr = 0; Pipe_Rd = 0; Pipe_Data = 0; Issue_Vld = 0; Issue_Rd = 0;
        LL_Vld = 0; LL_Rd = 0; LL_Data = 0; Rs1_rd = 0; Rs2_rd = 0; Rd_Chk = 0;
        #1;
        check("rst_reg_wr", 64'(Reg_Wr), 64'd0);
        check("rst_rd_wr", 64'(Rd_Wr), 64'd0);
        check("rst_rd_in", 64'(Rd_In), 64'd0);
        check("rst_busy", 64'(Busy_Vec), 64'd0);
        check("rst_ll_rdy", 64'(LL_Rdy), 64'd1);
        exp_q.delete();
        model_fifo.delete();
        ll_pend.delete();
        model_busy = '0;
        last_rd = '0;
        last_data = '0;
        repeat (2) @(negedge CLK);
        rst_n = 1'b1;
    endtask

    // Monitor: each cycle either the oldest expected write is due, or the port must be idle and holding.
    always @(posedge CLK) begin
        exp_t x;
        #1;
        if (rst_n) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                x = exp_q.pop_front();
                check("wr_en", 64'(Reg_Wr), 64'd1);
                check("wr_rd", 64'(Rd_Wr), 64'(x.e.rd));
                check("wr_data", 64'(Rd_In), 64'(x.e.data));
                last_rd = x.e.rd;
                last_data = x.e.data;
            end else begin
                check("idle_wr_en", 64'(Reg_Wr), 64'd0);
                check("hold_rd", 64'(Rd_Wr), 64'(last_rd));
                check("hold_data", 64'(Rd_In), 64'(last_data));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0]  rds[3];
        int          idx;
        bit          pw, iv, lv;
        logic [4:0]  prd, ird, lrd, rdc;

        rst_n = 1'b0;
        Pipe_Wr = 0; Pipe_Rd = 0; Pipe_Data = 0; Issue_Vld = 0; Issue_Rd = 0;
        LL_Vld = 0; LL_Rd = 0; LL_Data = 0; Rs1_rd = 0; Rs2_rd = 0; Rd_Chk = 0;
        model_busy = '0; last_rd = '0; last_data = '0;

        // Pipeline write right after reset release
        do_reset();
        step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Long-latency op: busy, stall, buffered write, busy clear
        issue(7);
        step(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0);
        step(0, 0, 0, 0, 0, 1, 7, 32'h11, 7, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 7, 7, 7);

        // Pipeline hogs the port while three results arrive; FIFO fills then drains in order
        rds[0] = 5'd1; rds[1] = 5'd2; rds[2] = 5'd3;
        for (int i = 0; i < 3; i++) issue(rds[i]);
        idx = 0;
        for (int i = 0; i < 4; i++) begin
            step(1, 5'(10 + i), 32'hA000 + i, 0, 0, idx < 3, (idx < 3) ? rds[idx] : 5'd0,
                 32'hB000 + idx, 1, 2, 3);
            if (last_acc) idx++;
        end
        while (idx < 3) begin
            step(0, 0, 0, 0, 0, 1, rds[idx], 32'hB000 + idx, 1, 2, 3);
            if (last_acc) idx++;
        end
        idle(4);

        // Pipeline write to x0 does not block the FIFO pop
        issue(9);
        step(1, 1, 32'h1111, 0, 0, 1, 9, 32'h9999, 0, 0, 0);
        step(1, 0, 32'hFFFF, 0, 0, 0, 0, 0, 9, 0, 0);
        idle(3);

        // Steady push+pop at DEPTH-1 occupancy across pointer wrap
        for (int i = 0; i < 6; i++) issue(5'(11 + i));
        step(1, 2, 32'h2222, 0, 0, 1, 11, 32'hC000, 0, 0, 0);
        for (int i = 1; i < 6; i++) step(0, 0, 0, 0, 0, 1, 5'(11 + i), 32'hC000 + i, 5'(11 + i), 0, 0);
        idle(4);

        // Reset with two buffered results and busy[3] set
        issue(3);
        issue(4);
        step(1, 1, 32'h1, 0, 0, 1, 3, 32'h33, 3, 0, 0);
        step(1, 1, 32'h2, 0, 0, 1, 4, 32'h44, 3, 4, 0);
        step(1, 1, 32'h3, 0, 0, 0, 0, 0, 3, 4, 0);
        do_reset();
        idle(2);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            pw  = ($urandom_range(0, 2) != 0);
            prd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            iv  = 1'b0;
            ird = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0 && !model_busy[ird] && ll_pend.size() < 6) iv = 1'b1;
            lv  = (ll_pend.size() > 0) && ($urandom_range(0, 1) == 1);
            lrd = (ll_pend.size() > 0) ? ll_pend[0] : 5'd0;
            rdc = iv ? ird : 5'($urandom_range(0, 31));
            step(pw, prd, $urandom, iv, ird, lv, lrd, $urandom,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), rdc);
            if (last_acc) void'(ll_pend.pop_front());
            if (iv) ll_pend.push_back(ird);
        end
        idle(8);
        check("exp_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
